// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder:
// FSM state encoding, alignment mask, error encoding and the access-legality check.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b00;

    localparam logic RSP_ERR = 1'b1;
    localparam logic RSP_OK  = 1'b0;

    // An access is illegal when it is not word aligned or its word index falls past the array.
    function automatic logic access_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != WORD_ALIGN_MASK) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised single-port storage: synchronous write, registered read, both gated by en.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one outstanding load/store, fixed wait
// states, then a single access cycle and a held response until the requester takes it.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 128,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output state_e            state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // valid/data are held unchanged by their source until that edge; ready never waits on valid.

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        wait_cnt_q;
    logic              cap_write_q;
    logic [31:0]       cap_addr_q;
    logic [DATA_W-1:0] cap_wdata_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rd_ok_q;
    logic              accept;
    logic              access;
    logic              acc_err;
    logic [DATA_W-1:0] arr_rdata;

    assign acc_err = access_err(cap_addr_q, DEPTH);

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        access      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Ready is masked while reset is held so nothing looks acceptable.
                req_ready_o = rst_i;
                accept      = req_valid_i;
                if (req_valid_i) begin
                    state_d = (WAIT_CYC > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                access  = 1'b1;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt_q  <= 4'd0;
            cap_write_q <= 1'b0;
            cap_addr_q  <= 32'd0;
            cap_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= RSP_OK;
            rd_ok_q     <= 1'b0;
        end else begin
            if (accept) begin
                cap_write_q <= req_write_i;
                cap_addr_q  <= req_addr_i;
                cap_wdata_q <= req_wdata_i;
                wait_cnt_q  <= WAIT_LOAD;
            end else if (state_q == ST_WAIT && wait_cnt_q != 4'd0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end

            if (access) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= acc_err ? RSP_ERR : RSP_OK;
                rd_ok_q     <= !cap_write_q && !acc_err;
            end else if (state_q == ST_RESP && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    // The array's read register has no reset, so its value is only exposed for good loads.
    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk_i),
        .en    (access && !acc_err),
        .we    (cap_write_q),
        .idx   (cap_addr_q[IDX_W+1:2]),
        .wdata (cap_wdata_q),
        .rdata (arr_rdata)
    );

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rd_ok_q ? arr_rdata : '0;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYC=2 and a WAIT_CYC=0 build driven with directed and
// random traffic; responses are scored against a plain word-array model of the memory.
`timescale 1ns/1ps
module tb_dmem_responder;
    import cpu_mem_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;
    localparam int NI     = 2;
    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;

    logic              clk = 1'b0;
    logic              rst_n     [NI];
    logic              req_valid [NI];
    logic              req_ready [NI];
    logic              req_write [NI];
    logic [31:0]       req_addr  [NI];
    logic [DATA_W-1:0] req_wdata [NI];
    logic              rsp_valid [NI];
    logic              rsp_ready [NI];
    logic [DATA_W-1:0] rsp_rdata [NI];
    logic              rsp_err   [NI];
    state_e            dbg_state [NI];

    int                checks   = 0;
    int                failures = 0;
    int unsigned       cyc      = 0;
    logic [DATA_W-1:0] model_mem [NI][DEPTH];
    logic [DATA_W:0]   exp_q [NI][$];
    int unsigned       lat_q [NI][$];
    bit                busy [NI];
    int                rdy_mode [NI];

    dmem_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYC(WAIT_A)) u_dut_a (
        .clk_i(clk), .rst_i(rst_n[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
        .rsp_err_o(rsp_err[0]), .state_o(dbg_state[0])
    );

    dmem_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYC(WAIT_B)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
        .rsp_err_o(rsp_err[1]), .state_o(dbg_state[1])
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic int wait_of(input int i);
        return (i == 0) ? WAIT_A : WAIT_B;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Memory behaviour from the access rules: returns {err, rdata}.
    function automatic logic [DATA_W:0] model_access(input int i, input logic wr,
                                                     input logic [31:0] addr,
                                                     input logic [DATA_W-1:0] wdata);
        int unsigned idx = addr >> 2;
        bit          err = (addr % 4 != 0) || (idx >= DEPTH);
        if (err) return {1'b1, {DATA_W{1'b0}}};
        if (wr) begin
            model_mem[i][idx] = wdata;
            return {1'b0, {DATA_W{1'b0}}};
        end
        return {1'b0, model_mem[i][idx]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input int i, input logic wr, input logic [31:0] addr,
                         input logic [DATA_W-1:0] wdata, input bit track,
                         output int unsigned acc_edge);
        int unsigned budget = 0;
        acc_edge     = 0;
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = addr;
        req_wdata[i] = wdata;
        while (!req_ready[i]) begin
            @(negedge clk);
            budget++;
            if (budget > 200) begin
                checks++;
                failures++;
                $display("FAIL %0d:req_accept_timeout actual=no_accept required=accept", i);
                req_valid[i] = 1'b0;
                return;
            end
        end
        acc_edge = cyc + 1;
        @(posedge clk);
        busy[i] = 1'b1;
        if (track) begin
            exp_q[i].push_back(model_access(i, wr, addr, wdata));
            lat_q[i].push_back(acc_edge + wait_of(i) + 1);
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom);
        req_addr[i]  = $urandom;
        req_wdata[i] = $urandom;
    endtask

    task automatic wait_idle(input int i);
        int unsigned budget = 0;
        while (busy[i] && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (busy[i]) begin
            checks++;
            failures++;
            $display("FAIL %0d:rsp_timeout actual=busy required=idle", i);
            busy[i] = 1'b0;
        end
    endtask

    task automatic random_op(input int i);
        logic [31:0] a;
        int unsigned e;
        a = {22'd0, 8'($urandom_range(0, DEPTH + 7)), 2'b00};
        if ($urandom_range(0, 7) == 0)  a[1:0]   = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) a[31:28] = 4'($urandom_range(1, 15));
        issue(i, 1'($urandom), a, $urandom, 1'b1, e);
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        check($sformatf("%0d:%s_rsp_valid", i, tag), rsp_valid[i], 1'b0);
        check($sformatf("%0d:%s_rsp_rdata", i, tag), rsp_rdata[i], '0);
        check($sformatf("%0d:%s_rsp_err", i, tag), rsp_err[i], 1'b0);
        check($sformatf("%0d:%s_req_ready", i, tag), req_ready[i], 1'b0);
        check($sformatf("%0d:%s_state", i, tag), dbg_state[i], ST_IDLE);
    endtask

    // ---------------- response-ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NI; i++) begin
                case (rdy_mode[i])
                    0:       rsp_ready[i] = 1'b1;
                    1:       rsp_ready[i] = ($urandom_range(0, 2) != 0);
                    default: rsp_ready[i] = 1'b0;
                endcase
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    bit              prev_hs    [NI];
    bit              prev_stall [NI];
    bit              prev_valid [NI];
    logic [DATA_W+1:0] prev_rsp [NI];

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n[i]) begin
                prev_hs[i]    = 1'b0;
                prev_stall[i] = 1'b0;
                prev_valid[i] = 1'b0;
                continue;
            end
            check($sformatf("%0d:req_ready", i), req_ready[i], !busy[i]);
            if (prev_hs[i])
                check($sformatf("%0d:rsp_valid_after_hs", i), rsp_valid[i], 1'b0);
            if (prev_stall[i])
                check($sformatf("%0d:rsp_hold", i), {rsp_valid[i], rsp_err[i], rsp_rdata[i]},
                      prev_rsp[i]);
            if (rsp_valid[i] && !prev_valid[i]) begin
                if (lat_q[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %0d:unexpected_rsp actual=valid required=no_response", i);
                end else begin
                    check($sformatf("%0d:rsp_latency", i), cyc, lat_q[i].pop_front());
                end
            end
            if (rsp_valid[i] && rsp_ready[i]) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %0d:rsp_data actual=0x%0h required=none", i,
                             {rsp_err[i], rsp_rdata[i]});
                end else begin
                    check($sformatf("%0d:rsp_data", i), {rsp_err[i], rsp_rdata[i]},
                          exp_q[i].pop_front());
                end
                busy[i] = 1'b0;
            end
            prev_hs[i]    = rsp_valid[i] && rsp_ready[i];
            prev_stall[i] = rsp_valid[i] && !rsp_ready[i];
            prev_valid[i] = rsp_valid[i];
            prev_rsp[i]   = {rsp_valid[i], rsp_err[i], rsp_rdata[i]};
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int unsigned e0, e1, e2;
        for (int i = 0; i < NI; i++) begin
            rst_n[i]     = 1'b0;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b1;
            rdy_mode[i]  = 0;
            busy[i]      = 1'b0;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check_reset_outputs(i, "reset");
        @(posedge clk);
        #2;
        for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
        @(negedge clk);

        // Known contents everywhere so every later load has a defined answer.
        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < DEPTH; w++) issue(i, 1'b1, 32'(w * 4), $urandom, 1'b1, e0);
            wait_idle(i);
        end

        // Store then load, with acceptance spacing WAIT_CYC+3.
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, e0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, e1);
        check("0:accept_spacing", e1 - e0, 5);
        wait_idle(0);

        // Misaligned accesses; errored store leaves the word alone.
        issue(0, 1'b0, 32'h12, 32'h0, 1'b1, e0);
        issue(0, 1'b1, 32'h13, 32'hBAD0BAD0, 1'b1, e0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, e0);
        // First word past the end, then the last valid word.
        issue(0, 1'b1, 32'h200, 32'hCAFEF00D, 1'b1, e0);
        issue(0, 1'b0, 32'h1FC, 32'h0, 1'b1, e0);
        wait_idle(0);

        // Response backpressure.
        rdy_mode[0] = 2;
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, e0);
        e1 = 0;
        while (!rsp_valid[0] && e1 < 50) begin
            @(negedge clk);
            e1++;
        end
        check("0:bp_rsp_seen", rsp_valid[0], 1'b1);
        repeat (5) @(negedge clk);
        check("0:bp_still_valid", rsp_valid[0], 1'b1);
        rdy_mode[0] = 0;
        wait_idle(0);

        // Reset while the store is still waiting: no write, no response.
        issue(0, 1'b1, 32'h20, 32'h12345678, 1'b0, e0);
        @(posedge clk);
        #2;
        rst_n[0] = 1'b0;
        busy[0]  = 1'b0;
        #1;
        check_reset_outputs(0, "midop_reset");
        repeat (3) @(negedge clk);
        check("0:midop_no_rsp", rsp_valid[0], 1'b0);
        @(posedge clk);
        #2;
        rst_n[0] = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 32'h20, 32'h0, 1'b1, e0);
        wait_idle(0);

        // Random traffic with random response backpressure.
        rdy_mode[0] = 1;
        for (int n = 0; n < 200; n++) random_op(0);
        wait_idle(0);
        rdy_mode[0] = 0;

        // Zero-wait build: request valid held across back-to-back operations.
        issue(1, 1'b1, 32'h40, 32'hA5A55A5A, 1'b1, e0);
        issue(1, 1'b0, 32'h40, 32'h0, 1'b1, e1);
        issue(1, 1'b0, 32'h1FC, 32'h0, 1'b1, e2);
        check("1:accept_spacing_a", e1 - e0, 3);
        check("1:accept_spacing_b", e2 - e1, 3);
        wait_idle(1);

        rdy_mode[1] = 1;
        for (int n = 0; n < 150; n++) random_op(1);
        wait_idle(1);
        rdy_mode[1] = 0;

        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%0d:exp_q_drained", i), exp_q[i].size(), 0);
            check($sformatf("%0d:lat_q_drained", i), lat_q[i].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
